// File: rtl/param_demux_stream_pkg.sv
// ---------------------------------------------------------------------------
// param_demux_pkg : shared routing-mode constants and one-hot legality check
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package param_demux_pkg;

  localparam logic RR_MODE  = 1'b1;
  localparam logic SEL_MODE = 1'b0;
  localparam int   MAX_CH   = 16;

  // True when exactly one bit of the (zero-extended) select vector is set.
  function automatic logic onehot_valid(input logic [MAX_CH-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (vec[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_demux_stream_if.sv
// ---------------------------------------------------------------------------
// param_demux_stream_if : producer/consumer bundle of the stream demultiplexer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface param_demux_stream_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int OUTPUT_CHANNELS = 2,
  parameter int DROP_CNT_WIDTH  = 8
);

  logic [DATA_WIDTH-1:0]                 in_data;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [OUTPUT_CHANNELS-1:0]            sel;
  logic                                  rr_mode;
  logic [OUTPUT_CHANNELS*DATA_WIDTH-1:0] out_data;
  logic [OUTPUT_CHANNELS-1:0]            out_valid;
  logic [OUTPUT_CHANNELS-1:0]            out_ready;
  logic                                  sel_err;
  logic [DROP_CNT_WIDTH-1:0]             drop_cnt;

  modport master (
    output in_data, in_valid, sel, rr_mode, out_ready,
    input  in_ready, out_data, out_valid, sel_err, drop_cnt
  );

  modport slave (
    input  in_data, in_valid, sel, rr_mode, out_ready,
    output in_ready, out_data, out_valid, sel_err, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/param_demux_stream_lane_slot.sv
// ---------------------------------------------------------------------------
// demux_lane_slot : 1-deep registered output slot with valid/ready
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module demux_lane_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  free_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // A draining slot counts as free so it can refill on the same edge.
  assign free_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = din_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign dout_o      = data_q;

endmodule

`default_nettype wire

// File: rtl/param_demux_stream.sv
// ---------------------------------------------------------------------------
// param_demux_stream : one input stream routed to OUTPUT_CHANNELS registered lanes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module param_demux_stream
  import param_demux_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int OUTPUT_CHANNELS = 2,
  parameter int DROP_CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  param_demux_stream_if.slave  s
);

  localparam int PTR_W = (OUTPUT_CHANNELS > 1) ? $clog2(OUTPUT_CHANNELS) : 1;

  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      sel_err_q, sel_err_d;

  logic [MAX_CH-1:0]          w_sel_ext;
  logic                       w_sel_legal;
  logic [PTR_W-1:0]           w_sel_idx;
  logic [PTR_W-1:0]           w_tgt;
  logic                       w_illegal;
  logic                       w_accept;
  logic [OUTPUT_CHANNELS-1:0] w_free;
  logic [OUTPUT_CHANNELS-1:0] w_load;
  logic [OUTPUT_CHANNELS-1:0] w_out_valid;
  logic [OUTPUT_CHANNELS*DATA_WIDTH-1:0] w_out_data;

  always_comb begin
    w_sel_ext = '0;
    w_sel_ext[OUTPUT_CHANNELS-1:0] = s.sel;
  end

  assign w_sel_legal = onehot_valid(w_sel_ext);

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < OUTPUT_CHANNELS; i++) begin
      if (s.sel[i]) w_sel_idx = PTR_W'(i);
    end
  end

  assign w_tgt     = (s.rr_mode == RR_MODE) ? rr_ptr_q : w_sel_idx;
  assign w_illegal = (s.rr_mode == SEL_MODE) && !w_sel_legal;

  // Illegal beats are always taken and discarded so the producer never stalls.
  assign s.in_ready = rst_n && (w_illegal || w_free[w_tgt]);
  assign w_accept   = s.in_valid && s.in_ready;

  always_comb begin
    w_load = '0;
    if (w_accept && !w_illegal) w_load[w_tgt] = 1'b1;
  end

  generate
    for (genvar g = 0; g < OUTPUT_CHANNELS; g++) begin : g_lane
      demux_lane_slot #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (w_load[g]),
        .din_i       (s.in_data),
        .out_ready_i (s.out_ready[g]),
        .out_valid_o (w_out_valid[g]),
        .dout_o      (w_out_data[g*DATA_WIDTH +: DATA_WIDTH]),
        .free_o      (w_free[g])
      );
    end
  endgenerate

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    drop_cnt_d = drop_cnt_q;
    sel_err_d  = 1'b0;
    if (w_accept && !w_illegal && (s.rr_mode == RR_MODE)) begin
      rr_ptr_d = (rr_ptr_q == PTR_W'(OUTPUT_CHANNELS - 1)) ? '0 : rr_ptr_q + PTR_W'(1);
    end
    if (w_accept && w_illegal) begin
      sel_err_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign s.out_valid = w_out_valid;
  assign s.out_data  = w_out_data;
  assign s.sel_err   = sel_err_q;
  assign s.drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_param_demux_stream.sv
// ---------------------------------------------------------------------------
// tb_param_demux_stream : scoreboard bench for the 4-lane stream demultiplexer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_param_demux_stream;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int CW = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_lane;
  logic [DW-1:0] sbq [NC][$];

  param_demux_stream_if #(.DATA_WIDTH(DW), .OUTPUT_CHANNELS(NC), .DROP_CNT_WIDTH(CW)) u_if ();

  param_demux_stream #(
    .DATA_WIDTH      (DW),
    .OUTPUT_CHANNELS (NC),
    .DROP_CNT_WIDTH  (CW)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [DW-1:0] d, input logic [NC-1:0] sl,
                       input logic rrm, input int lane);
    u_if.in_valid = vld;
    u_if.in_data  = d;
    u_if.sel      = sl;
    u_if.rr_mode  = rrm;
    exp_lane      = lane;
    #1;
  endtask

  function automatic logic [DW-1:0] lane_data(input int i);
    return u_if.out_data[i*DW +: DW];
  endfunction

  // Drains are compared before new beats are queued so per-lane order holds.
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (u_if.out_valid[i] && u_if.out_ready[i]) begin
        if (sbq[i].size() == 0) check_eq("sb_unexpected", 32'(i), 32'hFF);
        else check_eq("sb_lane_data", 32'(lane_data(i)), 32'(sbq[i].pop_front()));
      end
    end
    if (rst_n && u_if.in_valid && u_if.in_ready && exp_lane >= 0)
      sbq[exp_lane].push_back(u_if.in_data);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    u_if.out_ready = '0;
    drive(1'b1, 8'h11, 4'b0001, 1'b0, 0);

    // reset holds everything empty even with a beat offered
    repeat (3) step();
    check_eq("rst_in_ready", 32'(u_if.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("rst_out_data", u_if.out_data, 32'd0);
    check_eq("rst_drop_cnt", 32'(u_if.drop_cnt), 32'd0);
    check_eq("rst_sel_err", 32'(u_if.sel_err), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", 32'(u_if.in_ready), 32'd1);
    step();
    check_eq("rel_first_valid", 32'(u_if.out_valid), 32'b0001);
    check_eq("rel_first_data", 32'(lane_data(0)), 32'h11);
    u_if.out_ready = 4'b1111;
    drive(1'b0, 8'h00, 4'b0001, 1'b0, -1);
    step();
    check_eq("rel_drained", 32'(u_if.out_valid), 32'd0);

    // sel routing, one-cycle latency
    drive(1'b1, 8'hA5, 4'b0001, 1'b0, 0);
    step();
    check_eq("sel_lane0_valid", 32'(u_if.out_valid), 32'b0001);
    check_eq("sel_lane0_data", 32'(lane_data(0)), 32'hA5);
    drive(1'b1, 8'h3C, 4'b0010, 1'b0, 1);
    step();
    check_eq("sel_lane1_valid", 32'(u_if.out_valid), 32'b0010);
    check_eq("sel_lane1_data", 32'(lane_data(1)), 32'h3C);
    drive(1'b0, 8'h00, 4'b0000, 1'b0, -1);
    step();
    check_eq("sel_one_cycle", 32'(u_if.out_valid), 32'd0);

    // backpressure on lane0, then release with no bubble
    u_if.out_ready = 4'b1110;
    drive(1'b1, 8'h51, 4'b0001, 1'b0, 0);
    step();
    drive(1'b1, 8'h52, 4'b0001, 1'b0, 0);
    check_eq("bp_in_ready_low", 32'(u_if.in_ready), 32'd0);
    step();
    check_eq("bp_held_valid", 32'(u_if.out_valid[0]), 32'd1);
    check_eq("bp_held_data", 32'(lane_data(0)), 32'h51);
    check_eq("bp_still_blocked", 32'(u_if.in_ready), 32'd0);
    u_if.out_ready = 4'b1111;
    #1;
    check_eq("bp_in_ready_high", 32'(u_if.in_ready), 32'd1);
    step();
    check_eq("bp_next_valid", 32'(u_if.out_valid[0]), 32'd1);
    check_eq("bp_next_data", 32'(lane_data(0)), 32'h52);
    drive(1'b0, 8'h00, 4'b0000, 1'b0, -1);
    step();
    check_eq("bp_empty", 32'(u_if.out_valid), 32'd0);

    // same-cycle drain and reload of lane1
    u_if.out_ready = 4'b1101;
    drive(1'b1, 8'h66, 4'b0010, 1'b0, 1);
    step();
    u_if.out_ready = 4'b1111;
    drive(1'b1, 8'h77, 4'b0010, 1'b0, 1);
    check_eq("dl_in_ready", 32'(u_if.in_ready), 32'd1);
    step();
    check_eq("dl_valid", 32'(u_if.out_valid[1]), 32'd1);
    check_eq("dl_data", 32'(lane_data(1)), 32'h77);
    drive(1'b0, 8'h00, 4'b0000, 1'b0, -1);
    step();

    // illegal selects are swallowed and counted
    drive(1'b1, 8'hE1, 4'b0000, 1'b0, -1);
    check_eq("ill0_in_ready", 32'(u_if.in_ready), 32'd1);
    step();
    check_eq("ill0_sel_err", 32'(u_if.sel_err), 32'd1);
    check_eq("ill0_drop_cnt", 32'(u_if.drop_cnt), 32'd1);
    check_eq("ill0_no_valid", 32'(u_if.out_valid), 32'd0);
    drive(1'b1, 8'hE2, 4'b0011, 1'b0, -1);
    check_eq("ill1_in_ready", 32'(u_if.in_ready), 32'd1);
    step();
    check_eq("ill1_sel_err", 32'(u_if.sel_err), 32'd1);
    check_eq("ill1_drop_cnt", 32'(u_if.drop_cnt), 32'd2);
    check_eq("ill1_no_valid", 32'(u_if.out_valid), 32'd0);
    drive(1'b0, 8'h00, 4'b0000, 1'b0, -1);
    step();
    check_eq("ill_idle_sel_err", 32'(u_if.sel_err), 32'd0);
    check_eq("ill_idle_drop_cnt", 32'(u_if.drop_cnt), 32'd2);
    drive(1'b1, 8'hE3, 4'b0000, 1'b0, -1);
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 251) check_eq("sat_before", 32'(u_if.drop_cnt), 32'd254);
    end
    check_eq("sat_hold", 32'(u_if.drop_cnt), 32'd255);
    check_eq("sat_sel_err", 32'(u_if.sel_err), 32'd1);
    check_eq("sat_no_valid", 32'(u_if.out_valid), 32'd0);

    // reset mid-transfer drops the in-flight beat
    u_if.out_ready = 4'b0000;
    drive(1'b1, 8'h99, 4'b0100, 1'b0, 2);
    step();
    drive(1'b0, 8'h00, 4'b0000, 1'b0, -1);
    check_eq("mid_loaded", 32'(u_if.out_valid), 32'b0100);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("mid_rst_in_ready", 32'(u_if.in_ready), 32'd0);
    check_eq("mid_rst_drop_cnt", 32'(u_if.drop_cnt), 32'd0);
    for (int i = 0; i < NC; i++) sbq[i].delete();
    step();
    rst_n = 1'b1;
    u_if.out_ready = 4'b1111;
    step();

    // round-robin sweep from pointer 0
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(i), 4'b0000, 1'b1, i % NC);
      step();
      check_eq("rr_valid", 32'(u_if.out_valid), 32'(1 << (i % NC)));
    end
    drive(1'b1, 8'h06, 4'b0000, 1'b1, 2);
    step();
    check_eq("rr_ptr_end", 32'(u_if.out_valid), 32'b0100);
    check_eq("rr_ptr_data", 32'(lane_data(2)), 32'h06);
    drive(1'b0, 8'h00, 4'b0000, 1'b0, -1);
    repeat (3) step();

    for (int i = 0; i < NC; i++) check_eq("sb_empty", 32'(sbq[i].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
